// File: rtl/open_list_cmd_ctrl.sv
// Command front-end for the systolic open-list min-queue: turns valid/ready commands into
// single-cycle queue pulses, enforces a settle gap, returns results and tracks occupancy.
module open_list_cmd_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [1:0]            s_op,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_err,
  output logic                  q_wrt,
  output logic                  q_read,
  output logic [DATA_WIDTH-1:0] q_node_f,
  input  logic                  q_full,
  input  logic                  q_empty,
  input  logic [DATA_WIDTH-1:0] q_head,
  output logic [CNT_WIDTH-1:0]  o_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  localparam logic [1:0] OP_PEEK = 2'b00;
  localparam logic [1:0] OP_PUSH = 2'b01;
  localparam logic [1:0] OP_POP  = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                state, state_nxt;
  logic [GW-1:0]         gap_cnt;
  logic                  accept;
  logic                  wrt_d, rd_d, rsp_err, cnt_inc, cnt_dec;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign s_ready = (state == IDLE) && (!m_valid || m_ready);
  assign accept  = s_valid && s_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) state <= IDLE;
    else       state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_cnt == GW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)               gap_cnt <= '0;
    else if (state == ISSUE) gap_cnt <= GW'(GAP_CYCLES);
    else if (state == GAP)   gap_cnt <= gap_cnt - GW'(1);
  end

  // Decode against the queue flags seen in the accept cycle; results land in ISSUE.
  always_comb begin
    wrt_d    = 1'b0;
    rd_d     = 1'b0;
    rsp_data = s_data;
    rsp_err  = 1'b0;
    cnt_inc  = 1'b0;
    cnt_dec  = 1'b0;
    case (s_op)
      OP_PUSH: begin
        if (q_full) rsp_err = 1'b1;
        else begin
          wrt_d   = 1'b1;
          cnt_inc = 1'b1;
        end
      end
      OP_POP: begin
        if (q_empty) begin
          rsp_data = '1;
          rsp_err  = 1'b1;
        end else begin
          rd_d     = 1'b1;
          rsp_data = q_head;
          cnt_dec  = 1'b1;
        end
      end
      OP_REPL: begin
        wrt_d = 1'b1;
        rd_d  = 1'b1;
        if (q_empty) begin
          rsp_data = '1;
          cnt_inc  = 1'b1;
        end else begin
          rsp_data = q_head;
        end
      end
      OP_PEEK: begin
        rsp_data = q_head;
        rsp_err  = q_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_err    <= 1'b0;
      q_wrt    <= 1'b0;
      q_read   <= 1'b0;
      q_node_f <= '0;
      o_count  <= '0;
    end else begin
      q_wrt  <= accept && wrt_d;
      q_read <= accept && rd_d;
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= rsp_data;
        m_err   <= rsp_err;
        if (wrt_d) q_node_f <= s_data;
        if (cnt_inc && o_count != CNT_MAX)   o_count <= o_count + CNT_WIDTH'(1);
        else if (cnt_dec && o_count != '0)   o_count <= o_count - CNT_WIDTH'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/open_list_cmd_ctrl.md
Name: open_list_cmd_ctrl

Overview:
Command front-end for the systolic open-list min-queue. It accepts push, pop, replace and peek commands from the A* search engine over a valid/ready channel and issues single-cycle write/read pulses to the queue. It enforces a minimum settle gap between queue operations so the systolic swap network can propagate, and returns every command's result and error flag on a valid/ready response channel. It also keeps a shadow occupancy count.

Parameters:
DATA_WIDTH, 32, width of node f value; must match the queue.
GAP_CYCLES, 1, idle cycles required after each queue pulse before the next command is accepted (0 allowed).
CNT_WIDTH, 16, width of the occupancy counter.

Ports:
CLK  input  1  clock
RSTn  input  1  asynchronous active-low reset
s_valid  input  1  command valid
s_ready  output  1  command accepted when s_valid && s_ready
s_op  input  2  00 peek, 01 push, 10 pop, 11 replace
s_data  input  DATA_WIDTH  node f for push/replace
m_valid  output  1  response valid
m_ready  input  1  response consumed when m_valid && m_ready
m_data  output  DATA_WIDTH  response value
m_err  output  1  command rejected
q_wrt  output  1  to queue i_wrt
q_read  output  1  to queue i_read
q_node_f  output  DATA_WIDTH  to queue i_node_f
q_full  input  1  from queue o_full
q_empty  input  1  from queue o_empty
q_head  input  DATA_WIDTH  from queue o_node_f (current minimum)
o_count  output  CNT_WIDTH  shadow occupancy

Behaviour:
- Reset (RSTn low, asynchronous): state IDLE; m_valid=0, m_data=0, m_err=0, q_wrt=0, q_read=0, q_node_f=0, o_count=0, gap counter=0.
- FSM states: IDLE, ISSUE, GAP.
- s_ready = (state==IDLE) && (!m_valid || m_ready). It is combinational and equals 1 immediately after reset release.
- Accept in IDLE at cycle T: sample s_op, s_data, q_full, q_empty and q_head in cycle T, then go to ISSUE.
- ISSUE, cycle T+1 (exactly one cycle). Pulses are registered and driven from T+1:
  - push, !full: q_wrt=1, q_node_f=data; m_data=data, m_err=0; o_count+1.
  - push, full: no pulse; m_data=data, m_err=1.
  - pop, !empty: q_read=1; m_data=sampled head, m_err=0; o_count-1.
  - pop, empty: no pulse; m_data='1, m_err=1.
  - replace: q_wrt=q_read=1, q_node_f=data, m_err=0.
    - If !empty: m_data=sampled head, o_count unchanged.
    - If empty: m_data='1, o_count+1.
    - Full is legal and leaves o_count unchanged.
  - peek: no pulse; m_data=sampled head, m_err=sampled empty.
  - m_valid=1 from T+1 and held stable with m_data/m_err until m_ready.
- After ISSUE:
  - If GAP_CYCLES==0, go to IDLE.
  - Otherwise load the counter with GAP_CYCLES and go to GAP. The counter decrements each cycle; at 1, go to IDLE.
  - Peek and rejected commands also observe the gap, so timing is uniform.
- Minimum accept-to-accept spacing is GAP_CYCLES+2 cycles, provided m_ready is held high.
- Backpressure: the FSM never stalls in ISSUE or GAP. Only acceptance is blocked while a response is pending and not consumed in the same cycle.
- q_wrt and q_read are never asserted outside ISSUE. q_node_f holds its last value when idle.
- o_count saturates at 0 and at 2^CNT_WIDTH-1. It never wraps.
- s_op and s_data are ignored when s_valid is low or s_ready is low.
- Reset mid-operation (ISSUE or GAP, or pending response): everything returns to the reset values. A pending response is dropped and any pulse in flight is deasserted asynchronously.

Test Plan:
- GAP_CYCLES=2, m_ready=1; push 5 at T -> q_wrt=1 and q_node_f=5 only at T+1; m_valid at T+1 with m_data=5, m_err=0; s_ready low T+1..T+3, high at T+4; o_count=1.
- Push 9, 3, 7, then pop -> m_data=3, m_err=0, single q_read pulse, o_count=2; a following peek returns 7 (the head driven by the queue model).
- Pop on empty queue -> no q_read pulse; m_data=0xFFFFFFFF, m_err=1; o_count stays 0.
- Replace 4 with head 2, then replace 6 on empty -> first: q_wrt=q_read=1, m_data=2, count unchanged; second: m_data=0xFFFFFFFF, m_err=0, o_count+1.
- q_full=1, push 8 -> no pulse, m_err=1, m_data=8; replace 8 with q_full=1 -> both pulses, m_err=0.
- m_ready held low for 10 cycles after a push -> m_valid and m_data stable, s_ready=0 throughout. m_ready high -> s_ready goes high in the same cycle. Assert RSTn low during GAP -> all outputs return to 0 asynchronously.
